// File: rtl/rx_buffer_sequencer.sv
// rtl/rx_buffer_sequencer.sv - load/playback sequencer between UART receiver and sample buffer RAM
module rx_buffer_sequencer #(
  parameter int ADDR_W   = 4,
  parameter int RD_DELAY = 4,
  parameter int DELAY_W  = 4
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  input  logic               w_RX_DV,
  input  logic               SW,
  output logic               wr_en,
  output logic [ADDR_W:0]    count_w,
  output logic [ADDR_W-1:0]  count_r,
  output logic [DELAY_W-1:0] clk_delay,
  output logic               rd_valid,
  output logic               full,
  output logic               overflow,
  output logic               done
);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_READ, S_DONE} state_e;

  localparam logic [ADDR_W:0]    DEPTH_C   = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0]    ONE_W     = (ADDR_W+1)'(1);
  localparam logic [DELAY_W-1:0] LAST_WAIT = DELAY_W'(RD_DELAY-1);

  state_e               state_q, state_d;
  logic [ADDR_W:0]      count_w_q, count_w_d;
  logic [ADDR_W-1:0]    count_r_q, count_r_d;
  logic [DELAY_W-1:0]   clk_delay_q, clk_delay_d;
  logic                 overflow_q, overflow_d;
  logic                 full_c;
  logic                 wr_en_c;

  // Write enable: only in LOAD, never while full, and suppressed during reset
  // so a byte strobe coinciding with reset cannot corrupt the RAM.
  assign full_c  = (count_w_q == DEPTH_C);
  assign wr_en_c = (state_q == S_LOAD) & w_RX_DV & ~full_c & ~rst;

  assign wr_en     = wr_en_c;
  assign full      = full_c;
  assign count_w   = count_w_q;
  assign count_r   = count_r_q;
  assign clk_delay = clk_delay_q;
  assign overflow  = overflow_q;
  assign rd_valid  = (state_q == S_READ);
  assign done      = (state_q == S_DONE);

  // State and counter registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= S_LOAD;
      count_w_q   <= '0;
      count_r_q   <= '0;
      clk_delay_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_w_q   <= count_w_d;
      count_r_q   <= count_r_d;
      clk_delay_q <= clk_delay_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state logic: byte counting in LOAD, wait/read stepping in playback,
  // and a common abort back to LOAD whenever SW drops during playback.
  always_comb begin
    state_d     = state_q;
    count_w_d   = count_w_q;
    count_r_d   = count_r_q;
    clk_delay_d = clk_delay_q;
    overflow_d  = overflow_q;
    case (state_q)
      S_LOAD: begin
        if (wr_en_c) count_w_d = count_w_q + ONE_W;
        if (w_RX_DV && full_c) overflow_d = 1'b1;
        if (SW) begin
          clk_delay_d = '0;
          state_d     = (count_w_d != '0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (!SW) begin
          state_d     = S_LOAD;
          count_r_d   = '0;
          clk_delay_d = '0;
        end else if (clk_delay_q == LAST_WAIT) begin
          state_d     = S_READ;
          clk_delay_d = '0;
        end else begin
          clk_delay_d = clk_delay_q + 1'b1;
        end
      end
      S_READ: begin
        if (!SW) begin
          state_d     = S_LOAD;
          count_r_d   = '0;
          clk_delay_d = '0;
        end else if (({1'b0, count_r_q} + ONE_W) == count_w_q) begin
          state_d = S_DONE;
        end else begin
          count_r_d = count_r_q + 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_DONE: begin
        if (!SW) begin
          state_d     = S_LOAD;
          count_r_d   = '0;
          clk_delay_d = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

endmodule
